// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
// Stage payloads are packed side by side; stage_lsb() locates one of them.
package pipe_pkg;

    localparam int MAX_STAGES = 8;

    // Ceiling log2, usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Lowest bit of stage idx inside a packed STAGES*width payload bus.
    function automatic int stage_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register: payload plus valid bit.
// Flush beats load, and a bubble loads valid=0 while keeping the old payload.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              bubble,
    input  logic              flush,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic take;

    assign take = src_valid & ~bubble;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's value from before the edge, which is what makes it a chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload is reset as well as valid, so the whole chain
            // comes out of reset reading all zeros, not stale beats.
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= take;
            if (take) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// N-stage valid/payload register chain with per-stage hold, flush, global
// enable and a saturating count of the bubbles created by holds.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        hold,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam int IDX_W = clog2(MAX_STAGES);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipe_stage_chain: STAGES must be within 1..8");
    end

    logic [STAGES-1:0] frozen;
    logic [IDX_W-1:0]  hold_top;
    logic              hold_any;
    logic              bubble_inc;

    // A hold at stage j freezes j and everything upstream of it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        frozen             = '0;
        frozen[STAGES-1]   = ~enable | hold[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            frozen[i] = frozen[i+1] | hold[i];
        end
    end

    always_comb begin
        hold_top = '0;
        hold_any = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (hold[i]) begin
                hold_top = IDX_W'(i);
                hold_any = 1'b1;
            end
        end
    end

    // The stage just past the highest hold is the one that receives a bubble.
    assign bubble_inc = enable & hold_any & (hold_top < IDX_W'(STAGES - 1));
    assign in_ready   = ~frozen[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              src_valid;
        logic [DATA_W-1:0] src_data;
        logic              bubble;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign bubble    = 1'b0;
        end else begin : g_body
            assign src_valid = stage_valid[i-1];
            assign src_data  = stage_data[stage_lsb(i - 1, DATA_W) +: DATA_W];
            assign bubble    = frozen[i-1];
        end

        pipe_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (~frozen[i]),
            .bubble    (bubble),
            .flush     (enable & flush[i]),
            .src_valid (src_valid),
            .src_data  (src_data),
            .valid     (stage_valid[i]),
            .data      (stage_data[stage_lsb(i, DATA_W) +: DATA_W])
        );
    end

    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[stage_lsb(STAGES - 1, DATA_W) +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble_inc && bubble_cnt != {CNT_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: streaming, hold, flush, enable-low,
// counter saturation and mid-stream reset, with hand-computed expectations.
module tb_pipe_stage_chain;

    localparam int DATA_W = 32;
    localparam int STAGES = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic [STAGES-1:0]        hold;
    logic [STAGES-1:0]        flush;

    logic                     in_ready;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [15:0]              bubble_cnt;

    logic                     s_in_ready;
    logic [STAGES-1:0]        s_stage_valid;
    logic [STAGES*DATA_W-1:0] s_stage_data;
    logic                     s_out_valid;
    logic [DATA_W-1:0]        s_out_data;
    logic [3:0]               s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .hold        (hold),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .bubble_cnt  (bubble_cnt)
    );

    // Narrow-counter copy on the same stimulus, used for the saturation check.
    pipe_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(4)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (s_in_ready),
        .hold        (hold),
        .flush       (flush),
        .stage_valid (s_stage_valid),
        .stage_data  (s_stage_data),
        .out_valid   (s_out_valid),
        .out_data    (s_out_data),
        .bubble_cnt  (s_bubble_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [DATA_W-1:0] base);
        for (int i = 0; i < STAGES; i++) begin
            in_valid = 1'b1;
            in_data  = base + DATA_W'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        hold     = '0;
        flush    = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", stage_valid, 0);
        check("rst_data", stage_data, 0);
        check("rst_cnt", bubble_cnt, 0);
        check("rst_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("sat_rst", {s_in_ready, s_out_valid, s_stage_valid, s_out_data, s_bubble_cnt}, {1'b1, 1'b0, 4'b0, 32'b0, 4'b0});
        check("sat_rst_data", s_stage_data, 0);

        // Streaming 1..5: first beat out after the 4th edge, then back to back
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(k);
            step();
            if (k >= 4) begin
                check("stream_ov", out_valid, 1);
                check("stream_od", out_data, k - 3);
            end else begin
                check("stream_ov_early", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("stream_tail_ov", out_valid, 1);
            check("stream_tail_od", out_data, 3 + j);
        end
        step();
        check("stream_end_ov", out_valid, 0);

        // Hold stage 1 for two cycles with four beats in flight
        fill(32'h11);
        check("hold_pre_od", out_data, 32'h11);
        in_valid = 1'b1;
        in_data  = 32'h15;
        hold     = 4'b0010;
        #1 check("hold_ready1", in_ready, 0);
        step();
        check("hold_sv1", stage_valid, 4'b1011);
        check("hold_od1", out_data, 32'h12);
        check("hold_s0", stage_data[31:0], 32'h14);
        check("hold_s1", stage_data[63:32], 32'h13);
        check("hold_cnt1", bubble_cnt, 1);
        #1 check("hold_ready2", in_ready, 0);
        step();
        check("hold_sv2", stage_valid, 4'b0011);
        check("hold_cnt2", bubble_cnt, 2);
        hold = 4'b0000;
        #1 check("hold_ready3", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("hold_sv3", stage_valid, 4'b0111);
        for (int j = 0; j < 3; j++) begin
            step();
            check("hold_drain_ov", out_valid, 1);
            check("hold_drain_od", out_data, 32'h13 + j);
        end
        step();
        check("hold_drain_end", out_valid, 0);
        check("hold_cnt_final", bubble_cnt, 2);

        // Flush stages 0..2 while stage 0 is held
        fill(32'h21);
        check("flush_pre_sv", stage_valid, 4'b1111);
        hold  = 4'b0001;
        flush = 4'b0111;
        step();
        check("flush_sv", stage_valid, 4'b1000);
        check("flush_od", out_data, 32'h22);
        check("flush_s0_data", stage_data[31:0], 32'h24);
        check("flush_cnt", bubble_cnt, 3);
        hold  = 4'b0000;
        flush = 4'b0000;
        step();
        check("flush_after_sv", stage_valid, 4'b0000);

        // Enable low for three cycles: hold and flush must be ignored
        fill(32'h31);
        in_valid = 1'b1;
        in_data  = 32'h35;
        enable   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            hold  = (j == 0) ? 4'b0001 : 4'b0000;
            flush = (j == 1) ? 4'b0100 : 4'b0000;
            #1 check("en_ready", in_ready, 0);
            step();
            check("en_sv", stage_valid, 4'b1111);
            check("en_data", stage_data, {32'h31, 32'h32, 32'h33, 32'h34});
            check("en_cnt", bubble_cnt, 3);
        end
        enable = 1'b1;
        hold   = 4'b0000;
        flush  = 4'b0000;
        step();
        in_valid = 1'b0;
        check("en_resume_od", out_data, 32'h32);
        check("en_resume_s0", stage_data[31:0], 32'h35);
        step();
        check("en_resume_od2", out_data, 32'h33);
        step();
        step();
        step();

        // Reset mid-stream with all stages valid
        fill(32'h41);
        check("mrst_pre_sv", stage_valid, 4'b1111);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h45;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mrst_sv", stage_valid, 0);
        check("mrst_data", stage_data, 0);
        check("mrst_cnt", bubble_cnt, 0);
        check("mrst_ready", in_ready, 1);

        // Saturation of the 4-bit counter under a 20-cycle hold on stage 0
        hold = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            step();
            check("sat_cnt", s_bubble_cnt, (n < 15) ? n : 15);
        end
        check("wide_cnt", bubble_cnt, 20);
        hold = 4'b0000;
        step();
        check("sat_hold", s_bubble_cnt, 15);
        check("wide_cnt_stop", bubble_cnt, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
